// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared elaboration helpers for the servo PWM bank.
//   stop_code  - speed code that means "stop" for a given speed-word width
//   step_cyc   - clocks of pulse width per speed code (integer floor)
//   cnt_width  - bit width of the frame counter for a given period
package servo_pwm_pkg;

  function automatic int unsigned stop_code(input int unsigned speed_w);
    return 32'd1 << (speed_w - 1);
  endfunction

  function automatic int unsigned step_cyc(input int unsigned min_cyc,
                                           input int unsigned max_cyc,
                                           input int unsigned speed_w);
    return (max_cyc - min_cyc) / ((32'd1 << speed_w) - 32'd1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned period_cyc);
    return (period_cyc > 1) ? $clog2(period_cyc) : 1;
  endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// servo_pwm_bank_if: control/status bundle of the servo PWM bank.
//   en         - global output enable            (master -> slave)
//   speed      - packed per-channel speed words  (master -> slave)
//   pwm        - servo pulse outputs             (slave -> master)
//   frame_tick - one-cycle pulse at frame start  (slave -> master)
//   settled    - applied speed equals target     (slave -> master)
interface servo_pwm_bank_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SPEED_W  = 6
);
  logic                         en;
  logic [CHANNELS*SPEED_W-1:0]  speed;
  logic [CHANNELS-1:0]          pwm;
  logic                         frame_tick;
  logic [CHANNELS-1:0]          settled;

  modport master (
    output en,
    output speed,
    input  pwm,
    input  frame_tick,
    input  settled
  );

  modport slave (
    input  en,
    input  speed,
    output pwm,
    output frame_tick,
    output settled
  );
endinterface

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo output. Latches its target at each frame
// boundary (optionally mirrored), updates the applied speed, converts it to
// a pulse width and compares against the shared frame counter.
// Optional feature macro: SERVO_PWM_RAMP_EN (per-frame slew limit of RAMP_STEP).
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   boundary_i - frame boundary (shared counter == 0)
//   stop_i     - force applied speed to stop at this boundary
//   en_i       - output enable
//   cnt_i      - shared frame counter
//   speed_i    - requested speed word
//   pwm_o      - registered pulse output
//   settled_o  - applied speed equals latched target
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int unsigned SPEED_W   = 6,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned MIN_CYC   = 100_000,
  parameter int unsigned MAX_CYC   = 200_000,
  parameter bit          INVERT    = 1'b0,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               boundary_i,
  input  logic               stop_i,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               pwm_o,
  output logic               settled_o
);

  localparam logic [SPEED_W-1:0] StopCode = SPEED_W'(stop_code(SPEED_W));
  localparam logic [SPEED_W-1:0] MaxCode  = '1;
  localparam int unsigned        Step     = step_cyc(MIN_CYC, MAX_CYC, SPEED_W);

  logic [SPEED_W-1:0] target_q, target_d;
  logic [SPEED_W-1:0] cur_q, cur_d;
  logic [SPEED_W-1:0] speed_eff;
  logic [SPEED_W-1:0] ramp_next;
  logic [CNT_W-1:0]   width;
  logic               pwm_q, pwm_d;

  assign speed_eff = INVERT ? (MaxCode - speed_i) : speed_i;

  always_comb begin
    target_d = target_q;
    if (boundary_i) target_d = speed_eff;
  end

`ifdef SERVO_PWM_RAMP_EN
  localparam logic [SPEED_W-1:0] RampInc = SPEED_W'(RAMP_STEP);

  logic [SPEED_W-1:0] diff;

  // Step toward the freshly latched target, never past it.
  always_comb begin
    ramp_next = target_d;
    diff      = '0;
    if (target_d >= cur_q) begin
      diff = target_d - cur_q;
      if (32'(diff) > RAMP_STEP) ramp_next = cur_q + RampInc;
    end else begin
      diff = cur_q - target_d;
      if (32'(diff) > RAMP_STEP) ramp_next = cur_q - RampInc;
    end
  end
`else
  logic unused_ramp_step;
  assign unused_ramp_step = (RAMP_STEP != 0);

  always_comb ramp_next = target_d;
`endif

  always_comb begin
    cur_d = cur_q;
    if (boundary_i) cur_d = stop_i ? StopCode : ramp_next;
  end

  // Width uses cur_d so a new applied speed shapes the pulse of its own frame.
  assign width = CNT_W'(MIN_CYC) + CNT_W'(cur_d) * CNT_W'(Step);

  always_comb pwm_d = en_i && (cnt_i < width);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= StopCode;
      cur_q    <= StopCode;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign settled_o = (cur_q == target_q);

endmodule

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel frame-synchronous servo PWM generator.
// Owns the shared frame counter and frame_tick; one servo_pwm_channel per
// output. Optional feature macro: SERVO_PWM_RAMP_EN (per-frame slew limiter).
//   CLK100MHZ - system clock
//   rst_n     - asynchronous active-low reset
//   bus       - servo_pwm_bank_if slave: en, speed in; pwm, frame_tick, settled out
module servo_pwm_bank
  import servo_pwm_pkg::*;
#(
  parameter int unsigned          CHANNELS   = 2,
  parameter int unsigned          SPEED_W    = 6,
  parameter int unsigned          PERIOD_CYC = 2_000_000,
  parameter int unsigned          MIN_CYC    = 100_000,
  parameter int unsigned          MAX_CYC    = 200_000,
  parameter logic [CHANNELS-1:0]  INVERT     = 'b10,
  parameter int unsigned          RAMP_STEP  = 4
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  servo_pwm_bank_if.slave  bus
);

  localparam int unsigned     CntW    = cnt_width(PERIOD_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYC - 1);

  if (!((MIN_CYC < MAX_CYC) && (MAX_CYC < PERIOD_CYC))) begin : g_bad_cfg
    $error("servo_pwm_bank: MIN_CYC < MAX_CYC < PERIOD_CYC is required");
  end

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                frame_tick_q;
  logic                stop_pend_q, stop_pend_d;
  logic                boundary;
  logic                stop_now;
  logic [CHANNELS-1:0] pwm;
  logic [CHANNELS-1:0] settled;

  assign boundary = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (cnt_q == CntLast) cnt_d = '0;
  end

  // Any disable during a frame sends the wheels to stop at the next boundary,
  // even if en has come back by then, so re-enabling always starts from stop.
  assign stop_now = stop_pend_q || !bus.en;

  always_comb begin
    stop_pend_d = stop_now;
    if (boundary) stop_pend_d = !bus.en;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= boundary;
      stop_pend_q  <= stop_pend_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    servo_pwm_channel #(
      .SPEED_W   (SPEED_W),
      .CNT_W     (CntW),
      .MIN_CYC   (MIN_CYC),
      .MAX_CYC   (MAX_CYC),
      .INVERT    (INVERT[i]),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk_i      (CLK100MHZ),
      .rst_ni     (rst_n),
      .boundary_i (boundary),
      .stop_i     (stop_now),
      .en_i       (bus.en),
      .cnt_i      (cnt_q),
      .speed_i    (bus.speed[i*SPEED_W +: SPEED_W]),
      .pwm_o      (pwm[i]),
      .settled_o  (settled[i])
    );
  end

  assign bus.pwm        = pwm;
  assign bus.settled    = settled;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: scoreboard bench for servo_pwm_bank.
// Stimulus pushes the expected per-frame pulse widths and settled flags; a
// monitor measures each completed frame and pops/compares.
// Builds with or without SERVO_PWM_RAMP_EN.
module tb_servo_pwm_bank;

  localparam int unsigned PERIOD = 1000;

  typedef struct {
    int         w0;
    int         w1;
    logic [1:0] set;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  servo_pwm_bank_if #(.CHANNELS(2), .SPEED_W(6)) bus ();

  servo_pwm_bank #(
    .CHANNELS   (2),
    .SPEED_W    (6),
    .PERIOD_CYC (PERIOD),
    .MIN_CYC    (100),
    .MAX_CYC    (226),
    .INVERT     (2'b10),
    .RAMP_STEP  (4)
  ) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int w0, input int w1, input logic [1:0] s, input string n);
    exp_t e;
    e.w0   = w0;
    e.w1   = w1;
    e.set  = s;
    e.name = n;
    exp_q.push_back(e);
  endtask

  // Advance to the next negedge where frame_tick is high (cnt == 1 cycle).
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 3 * PERIOD);
    if (!bus.frame_tick) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: got 0, expected 1 within %0d cycles", 3 * PERIOD);
    end
  endtask

  // From the frame_tick negedge (cnt == 1) move to the negedge of cnt == k.
  task automatic wait_to_cnt(input int k);
    repeat (k - 1) @(negedge clk);
  endtask

  // Monitor: accumulate high cycles per frame, compare when the frame closes.
  initial begin
    int   hi0;
    int   hi1;
    bit   in_frame;
    logic [1:0] set_seen;
    exp_t e;
    hi0      = 0;
    hi1      = 0;
    in_frame = 1'b0;
    set_seen = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else begin
        if (bus.frame_tick) begin
          if (in_frame) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got widths %0d/%0d, expected none", hi0, hi1);
            end else begin
              e = exp_q.pop_front();
              check({e.name, "_w0"}, hi0, e.w0);
              check({e.name, "_w1"}, hi1, e.w1);
              check({e.name, "_settled"}, int'(set_seen), int'(e.set));
            end
          end
          in_frame = 1'b1;
          hi0      = 0;
          hi1      = 0;
          set_seen = bus.settled;
        end
        if (in_frame) begin
          hi0 += int'(bus.pwm[0]);
          hi1 += int'(bus.pwm[1]);
        end
      end
    end
  end

  initial begin
`ifdef SERVO_PWM_RAMP_EN
    int r0[8];
    int r1[8];
    r0 = '{172, 180, 188, 196, 204, 212, 220, 226};
    r1 = '{156, 148, 140, 132, 124, 116, 108, 100};
`endif
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    // ch1 is mirrored: its stop code on the wire is 31.
    bus.speed = {6'd31, 6'd32};
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(bus.pwm), 0);
    check("reset_frame_tick", int'(bus.frame_tick), 0);
    check("reset_settled", int'(bus.settled), 3);
    rst_n = 1'b1;

    wait_tick();
    push(164, 164, 2'b11, "stop");
    wait_tick();
    push(164, 164, 2'b11, "stop2");
    wait_to_cnt(10);
    bus.speed = {6'd63, 6'd63};
    wait_tick();

`ifdef SERVO_PWM_RAMP_EN
    for (int i = 0; i < 8; i++) begin
      push(r0[i], r1[i], (i == 7) ? 2'b11 : 2'b00, "ramp");
      wait_tick();
    end
`else
    push(226, 100, 2'b11, "invert");
    wait_tick();
    push(226, 100, 2'b11, "invert2");
    wait_tick();
`endif

    // Mid-frame speed change must not disturb the running frame.
    push(226, 100, 2'b11, "midframe_hold");
    wait_to_cnt(500);
    bus.speed = {6'd31, 6'd48};
    wait_tick();
`ifdef SERVO_PWM_RAMP_EN
    push(218, 108, 2'b00, "midframe_apply");
`else
    push(196, 164, 2'b11, "midframe_apply");
`endif
    wait_tick();

    // Disable at cnt 50, re-enable before the boundary.
`ifdef SERVO_PWM_RAMP_EN
    push(50, 50, 2'b00, "disable_frame");
`else
    push(50, 50, 2'b11, "disable_frame");
`endif
    wait_to_cnt(50);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("disable_next_cycle", int'(bus.pwm), 0);
    repeat (450) @(negedge clk);
    bus.en = 1'b1;
    wait_tick();
    push(164, 164, 2'b10, "reenable_stop");
    wait_tick();
`ifdef SERVO_PWM_RAMP_EN
    push(172, 164, 2'b10, "reenable_ramp");
    wait_tick();
    push(180, 164, 2'b10, "reenable_ramp2");
`else
    push(196, 164, 2'b11, "reenable_ramp");
    wait_tick();
    push(196, 164, 2'b11, "reenable_ramp2");
`endif
    wait_tick();

    // Asynchronous reset in the middle of both pulses.
    wait_to_cnt(80);
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(bus.pwm), 0);
    check("async_reset_settled", int'(bus.settled), 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_frame_tick", int'(bus.frame_tick), 1);
`ifdef SERVO_PWM_RAMP_EN
    push(172, 164, 2'b10, "after_reset");
`else
    push(196, 164, 2'b11, "after_reset");
`endif
    wait_tick();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Parametrised multi-channel PWM generator for continuous-rotation wheel servos, replacing the fixed two-wheel driver in `nexys`. It converts per-channel unsigned speed words into frame-synchronous servo pulses, drives them to JD pins, and supports per-channel direction inversion for mirrored wheels. It also has an optional per-frame slew limiter, so speed changes never jerk the chassis.

## Interface
- `CHANNELS`, 2, number of servo outputs
- `SPEED_W`, 6, speed word width; code 2^(SPEED_W-1) is stop
- `PERIOD_CYC`, 2_000_000, frame length in clocks (20 ms at 100 MHz)
- `MIN_CYC`, 100_000, pulse width for effective speed 0
- `MAX_CYC`, 200_000, nominal pulse width for full speed
- `INVERT`, 'b10, per-channel mask; bit set means the speed is mirrored
- `RAMP_STEP`, 4, maximum change of applied speed per frame (ramp build only)
- `CLK100MHZ`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  global output enable
- `speed`  in  CHANNELS*SPEED_W  target speeds; channel i is at `[i*SPEED_W +: SPEED_W]`
- `pwm`  out  CHANNELS  servo pulse outputs
- `frame_tick`  out  1  one-cycle pulse on the first cycle of each frame
- `settled`  out  CHANNELS  applied speed equals the latched target

## Operation
- **Frame counter** `cnt` counts 0..PERIOD_CYC-1 and then wraps. Frame boundary: `cnt == 0`.
- **Target latch:** at each boundary, each channel latches its target.
  - Target is `speed[i]`, or `(2^SPEED_W-1) - speed[i]` if `INVERT[i]`.
  - Mid-frame changes to `speed` are ignored until the next boundary.
- **Applied speed** `cur[i]` is updated at the boundary (see Configuration).
- **Pulse width:**
  - `width[i] = MIN_CYC + cur[i] * STEP`.
  - `STEP = (MAX_CYC - MIN_CYC) / (2^SPEED_W - 1)`, computed at elaboration with integer floor.
  - The multiply is unsigned; width is sized to `$clog2(PERIOD_CYC)` bits.
- **Output:** `pwm[i]` is high while `cnt < width[i]` and `en` is 1. The output is registered.
- **Disable:**
  - `en` = 0 forces all `pwm` low from the next cycle.
  - The counter keeps running.
  - At the next boundary, `cur` is reset to midpoint, so re-enable starts from stop.
- **settled:** `settled[i] = (cur[i] == target[i])`.
- **Elaboration check:** MIN_CYC < MAX_CYC < PERIOD_CYC is required; the checker errors otherwise.

## Timing
- **Reset values:**
  - `cnt` = 0.
  - `cur` and `target` = 2^(SPEED_W-1).
  - `pwm` = 0, `frame_tick` = 0.
  - `settled` = all ones.
- **First frame:** the first boundary occurs on the first clock after `rst_n` deasserts.
- **frame_tick** is registered. It is high in the cycle where `cnt == 1`, which is the same cycle `pwm` first rises.
- **Latency:** a new `cur` appears in the `pwm` width of the same frame it was updated in. The rising edge is 1 cycle after the boundary.
- **Width at or above PERIOD_CYC:** `pwm` stays high the whole frame (not reachable with legal parameters).
- **Reset mid-frame:** outputs drop immediately (asynchronous reset). No partial pulse is emitted after release.

## Configuration
- Macro: `SERVO_PWM_RAMP_EN`.
- **Defined:** at each boundary, `cur` moves toward `target` by at most `RAMP_STEP`, clamped so it never overshoots.
- **Undefined:**
  - `cur = target` at every boundary.
  - `RAMP_STEP` is ignored.
  - `settled` is 1 from the cycle after each boundary.

## Structure
- **Package `servo_pwm_pkg`:**
  - `STOP_CODE` function of `SPEED_W`.
  - `STEP` computation function.
  - `cnt_t` width helper (`$clog2` of the period).
- **Sub-module `servo_pwm_channel`:** one per channel via generate. It holds target latch, ramp, width multiply and compare.
- **Top level:** owns the shared counter and `frame_tick`.

## Test plan
Bench parameters: `PERIOD_CYC`=1000, `MIN_CYC`=100, `MAX_CYC`=226 (STEP=2), `SPEED_W`=6, `INVERT`='b10, `RAMP_STEP`=4.
- **Reset/stop:** `en`=1, speed 32 on both channels → both `pwm` high for 164 cycles per 1000, `settled`=11.
- **Inversion, no ramp:** ch0=63, ch1=63 → ch0 high 226 cycles, ch1 high 100 cycles from the next frame.
- **Ramp:** with macro defined, ch0 steps from 32 to 63 → widths 172, 180, …, 220, 226 over 8 consecutive frames. `settled[0]` is 0 until the 8th boundary.
- **Mid-frame change:** `speed` changes at `cnt`=500 → the current frame's width is unchanged; the new target is applied at the next boundary.
- **Disable:** `en`=0 at `cnt`=50 → `pwm` low from the next cycle. After re-enable, the pulse is 164 cycles, then ramps.
- **Async reset mid-pulse:** `rst_n` low at `cnt`=80 → `pwm`=0 in the same cycle; counter restarts at 0 after release.
